// File: rtl/weight_feeder_pkg.sv
// Shared types and helpers for the weight feeder: bitwidth codes, beat counts
// per code, and the sequencer state encoding.
package weight_pkg;

  localparam logic [2:0] BW_2B = 3'b001;
  localparam logic [2:0] BW_4B = 3'b010;
  localparam logic [2:0] BW_8B = 3'b100;

  typedef enum logic {
    IDLE,
    ISSUE
  } feeder_state_t;

  // Any code that is not one of the three one-hot values is treated as 8b.
  function automatic logic [2:0] bw_norm(input logic [2:0] bw);
    case (bw)
      BW_2B, BW_4B, BW_8B: return bw;
      default:             return BW_8B;
    endcase
  endfunction

  function automatic logic [2:0] beats_for(input logic [2:0] bw);
    case (bw)
      BW_2B:   return 3'd1;
      BW_4B:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/weight_feeder_if.sv
// Write-side and beat-side signals of the weight feeder. zero_skip exists only
// when WEIGHT_FEEDER_ZERO_SKIP_EN is defined.
interface weight_feeder_if #(
  parameter int DATA_W = 32
);
  logic [2:0]        weight_bitwidth;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              hold;
  logic              full;
  logic              empty;
  logic              overflow;
  logic              rd_en;
  logic [DATA_W-1:0] data_out;
  logic [2:0]        bw_out;
  logic              word_done;
`ifdef WEIGHT_FEEDER_ZERO_SKIP_EN
  logic              zero_skip;
`endif

  modport master (
    output weight_bitwidth, wr_en, wr_data, hold,
    input  full, empty, overflow, rd_en, data_out, bw_out, word_done
`ifdef WEIGHT_FEEDER_ZERO_SKIP_EN
    , input zero_skip
`endif
  );

  modport slave (
    input  weight_bitwidth, wr_en, wr_data, hold,
    output full, empty, overflow, rd_en, data_out, bw_out, word_done
`ifdef WEIGHT_FEEDER_ZERO_SKIP_EN
    , output zero_skip
`endif
  );

endinterface

// File: rtl/weight_feeder_sync_fifo.sv
// Single-clock FIFO with simultaneous push/pop; a push while full is accepted
// only when a pop happens in the same cycle.
module sync_fifo #(
  parameter  int DEPTH = 8,
  parameter  int WIDTH = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             push;
  logic             pop;

  always_comb begin
    full  = (count == CW'(DEPTH));
    empty = (count == '0);
    pop   = rd_en && !empty;
    push  = wr_en && (!full || pop);
  end

  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + CW'(1);
      if (pop)  rd_ptr <= rd_ptr + CW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: rtl/weight_feeder.sv
// Weight-word FIFO plus beat sequencer replaying each word 4/2/1 times for the
// bit-serial mux. Optional zero-word skipping: WEIGHT_FEEDER_ZERO_SKIP_EN.
module weight_feeder
  import weight_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32
) (
  input logic             clk,
  input logic             RST,
  weight_feeder_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  feeder_state_t     state, state_nx;
  logic [1:0]        cnt, cnt_nx;
  logic [AW:0]       count;
  logic [DATA_W-1:0] head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              go, issue, skip, pop, push, last_beat, at_boundary, more;
  logic [2:0]        eff_bw;
  logic [2:0]        nbeats;

  logic              rd_en_q;
  logic [DATA_W-1:0] data_q;
  logic [2:0]        bw_q;
  logic              done_q;
  logic              ovf_q;
`ifdef WEIGHT_FEEDER_ZERO_SKIP_EN
  logic              zs_q;
`endif

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (RST),
    .wr_en   (bus.wr_en),
    .wr_data (bus.wr_data),
    .rd_en   (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (count)
  );

  // The bitwidth is taken from the input only on the first beat of a word;
  // later beats reuse the value registered alongside that first beat.
  always_comb begin
    at_boundary = (state == IDLE) || (cnt == 2'd0);
    eff_bw      = at_boundary ? bw_norm(bus.weight_bitwidth) : bw_q;
    nbeats      = beats_for(eff_bw);
    go          = !fifo_empty && !bus.hold;
`ifdef WEIGHT_FEEDER_ZERO_SKIP_EN
    skip        = go && at_boundary && (head == '0);
`else
    skip        = 1'b0;
`endif
    issue       = go && !skip;
    last_beat   = ({1'b0, cnt} == (nbeats - 3'd1));
    pop         = skip || (issue && last_beat);
    push        = bus.wr_en && (!fifo_full || pop);
    more        = (count > CW'(1)) || push;
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      IDLE:  if (issue || skip) state_nx = ISSUE;
      ISSUE: state_nx = ISSUE;
      default: state_nx = IDLE;
    endcase
    if (pop) state_nx = more ? ISSUE : IDLE;
    if (issue) cnt_nx = last_beat ? 2'd0 : cnt + 2'd1;
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      rd_en_q <= 1'b0;
      data_q  <= '0;
      bw_q    <= BW_8B;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef WEIGHT_FEEDER_ZERO_SKIP_EN
      zs_q    <= 1'b0;
`endif
    end else begin
      rd_en_q <= issue;
      done_q  <= issue && last_beat;
      if (issue) begin
        data_q <= head;
        bw_q   <= eff_bw;
      end
      if (bus.wr_en && fifo_full && !pop) ovf_q <= 1'b1;
`ifdef WEIGHT_FEEDER_ZERO_SKIP_EN
      zs_q    <= skip;
`endif
    end
  end

  assign bus.full      = fifo_full;
  assign bus.empty     = fifo_empty;
  assign bus.overflow  = ovf_q;
  assign bus.rd_en     = rd_en_q;
  assign bus.data_out  = data_q;
  assign bus.bw_out    = bw_q;
  assign bus.word_done = done_q;
`ifdef WEIGHT_FEEDER_ZERO_SKIP_EN
  assign bus.zero_skip = zs_q;
`endif

endmodule
